// File: rtl/i2s_audio_rx.sv
// I2S receiver: synchronizes bclk/lrclk/sdata, deserializes MSB-first words and presents L/R pairs.
// Optional macro I2S_RX_MONO_MIX_EN adds pcm_mono = (pcm_l + pcm_r) >>> 1, updated with each pair.
module i2s_audio_rx #(
    parameter int unsigned audio_bits = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [audio_bits-1:0] pcm_l,
    output logic [audio_bits-1:0] pcm_r,
    output logic                  sample_valid,
`ifdef I2S_RX_MONO_MIX_EN
    output logic [audio_bits-1:0] pcm_mono,
`endif
    output logic                  frame_error
);

    localparam int unsigned CNT_W = $clog2(audio_bits + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(audio_bits);
    localparam logic [CNT_W-1:0] TOP  = CNT_W'(audio_bits - 1);

    typedef enum logic [1:0] {UNSYNC, LEFT, RIGHT} state_e;

    state_e                state_q, state_d;
    logic [1:0]            bclk_sync_q, bclk_sync_d;
    logic [1:0]            lr_sync_q, lr_sync_d;
    logic [1:0]            sd_sync_q, sd_sync_d;
    logic                  bclk_prev_q, bclk_prev_d;
    logic                  lr_prev_q, lr_prev_d;
    logic [audio_bits-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [audio_bits-1:0] left_hold_q, left_hold_d;
    logic                  left_pend_q, left_pend_d;
    logic [audio_bits-1:0] pcm_l_q, pcm_l_d;
    logic [audio_bits-1:0] pcm_r_q, pcm_r_d;
    logic                  sv_q, sv_d;
    logic                  fe_q, fe_d;

    logic                  rise_c;
    logic                  lr_s;
    logic                  sd_s;
    logic [audio_bits-1:0] shift_w;
    logic [CNT_W-1:0]      count_w;

`ifdef I2S_RX_MONO_MIX_EN
    logic [audio_bits-1:0] pcm_mono_q, pcm_mono_d;
    logic [audio_bits:0]   mono_sum;

    // Sign-extended sum of the pair being loaded; its upper bits are the >>>1 result
    assign mono_sum = {left_hold_q[audio_bits-1], left_hold_q} + {shift_w[audio_bits-1], shift_w};
    assign pcm_mono = pcm_mono_q;
`endif

    assign lr_s   = lr_sync_q[1];
    assign sd_s   = sd_sync_q[1];
    assign rise_c = bclk_sync_q[1] & ~bclk_prev_q;

    // Word with the current bit placed MSB-first; count saturates at a full word
    always_comb begin
        shift_w = shift_q;
        count_w = count_q;
        if (count_q < FULL) begin
            shift_w = shift_q | (audio_bits'(sd_s) << (TOP - count_q));
            count_w = count_q + CNT_W'(1);
        end
    end

    always_comb begin
        bclk_sync_d = {bclk_sync_q[0], bclk};
        lr_sync_d   = {lr_sync_q[0], lrclk};
        sd_sync_d   = {sd_sync_q[0], sdata};
        bclk_prev_d = bclk_sync_q[1];
        state_d     = state_q;
        lr_prev_d   = lr_prev_q;
        shift_d     = shift_q;
        count_d     = count_q;
        left_hold_d = left_hold_q;
        left_pend_d = left_pend_q;
        pcm_l_d     = pcm_l_q;
        pcm_r_d     = pcm_r_q;
        sv_d        = 1'b0;
        fe_d        = 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
        pcm_mono_d  = pcm_mono_q;
`endif
        if (rise_c) begin
            lr_prev_d = lr_s;
            if (lr_s == lr_prev_q) begin
                if (state_q != UNSYNC) begin
                    shift_d = shift_w;
                    count_d = count_w;
                end
            end else begin
                // Channel boundary: this bit closes the ending word, which commits unless unsynced
                state_d = lr_s ? RIGHT : LEFT;
                shift_d = '0;
                count_d = '0;
                if (state_q != UNSYNC) begin
                    fe_d = (count_w < FULL);
                    if (!lr_prev_q) begin
                        left_hold_d = shift_w;
                        left_pend_d = 1'b1;
                    end else if (left_pend_q) begin
                        pcm_l_d     = left_hold_q;
                        pcm_r_d     = shift_w;
                        sv_d        = 1'b1;
                        left_pend_d = 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
                        pcm_mono_d  = mono_sum[audio_bits:1];
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UNSYNC;
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            shift_q     <= '0;
            count_q     <= '0;
            left_hold_q <= '0;
            left_pend_q <= 1'b0;
            pcm_l_q     <= '0;
            pcm_r_q     <= '0;
            sv_q        <= 1'b0;
            fe_q        <= 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
            pcm_mono_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bclk_sync_q <= bclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            sd_sync_q   <= sd_sync_d;
            bclk_prev_q <= bclk_prev_d;
            lr_prev_q   <= lr_prev_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            left_hold_q <= left_hold_d;
            left_pend_q <= left_pend_d;
            pcm_l_q     <= pcm_l_d;
            pcm_r_q     <= pcm_r_d;
            sv_q        <= sv_d;
            fe_q        <= fe_d;
`ifdef I2S_RX_MONO_MIX_EN
            pcm_mono_q  <= pcm_mono_d;
`endif
        end
    end

    assign pcm_l        = pcm_l_q;
    assign pcm_r        = pcm_r_q;
    assign sample_valid = sv_q;
    assign frame_error  = fe_q;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: slot-level I2S driver, queue-based word model checked every cycle,
// plus literal expectations per scenario (mono checks when I2S_RX_MONO_MIX_EN is defined).
module tb_i2s_audio_rx;
    localparam int unsigned AB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic [AB-1:0] pcm_l;
    logic [AB-1:0] pcm_r;
    logic          sample_valid;
    logic          frame_error;
`ifdef I2S_RX_MONO_MIX_EN
    logic [AB-1:0] pcm_mono;
`endif

    i2s_audio_rx #(.audio_bits(AB)) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .pcm_l        (pcm_l),
        .pcm_r        (pcm_r),
        .sample_valid (sample_valid),
`ifdef I2S_RX_MONO_MIX_EN
        .pcm_mono     (pcm_mono),
`endif
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: per-rise (lrclk, sdata) records turned into expected output events keyed by cycle
    bit            m_unsync = 1'b1;
    bit            m_lrprev = 1'b0;
    bit            m_bits[$];
    bit            m_lpend = 1'b0;
    logic [AB-1:0] m_lword = '0;

    bit            ev_rst[int];
    bit            ev_sv[int];
    bit            ev_fe[int];
    logic [AB-1:0] ev_l[int];
    logic [AB-1:0] ev_r[int];

    function automatic logic [AB-1:0] mono_of(input logic [AB-1:0] l, input logic [AB-1:0] r);
        int s;
        s = int'($signed(l)) + int'($signed(r));
        return AB'(s >>> 1);
    endfunction

    task automatic model_rise(input bit lr, input bit sd, input int at);
        logic [AB-1:0] word;
        if (m_unsync) begin
            if (lr != m_lrprev) begin
                m_unsync = 1'b0;
                m_bits.delete();
            end
        end else begin
            m_bits.push_back(sd);
            if (lr != m_lrprev) begin
                word = '0;
                for (int i = 0; i < int'(AB); i++)
                    if (i < m_bits.size()) word[int'(AB) - 1 - i] = m_bits[i];
                ev_fe[at] = (m_bits.size() < int'(AB));
                m_bits.delete();
                if (!m_lrprev) begin
                    m_lword = word;
                    m_lpend = 1'b1;
                end else if (m_lpend) begin
                    ev_sv[at] = 1'b1;
                    ev_l[at]  = m_lword;
                    ev_r[at]  = word;
                    m_lpend   = 1'b0;
                end
            end
        end
        m_lrprev = lr;
    endtask

    task automatic model_reset(input int at);
        ev_rst[at] = 1'b1;
        m_unsync   = 1'b1;
        m_lrprev   = 1'b0;
        m_lpend    = 1'b0;
        m_bits.delete();
    endtask

    // Per-cycle comparison against the model
    logic [AB-1:0] cur_l = '0;
    logic [AB-1:0] cur_r = '0;
    int            sv_seen = 0;
    int            fe_seen = 0;
    int            last_sv_cyc = 0;
    int            last_rise_cyc = 0;

    always begin
        bit exp_sv;
        bit exp_fe;
        @(posedge clk);
        #1;
        if (ev_rst.exists(cyc)) begin
            cur_l = '0;
            cur_r = '0;
        end
        exp_sv = ev_sv.exists(cyc);
        exp_fe = ev_fe.exists(cyc) ? ev_fe[cyc] : 1'b0;
        if (exp_sv) begin
            cur_l = ev_l[cyc];
            cur_r = ev_r[cyc];
        end
        chk("cyc_sample_valid", 32'(sample_valid), 32'(exp_sv));
        chk("cyc_frame_error", 32'(frame_error), 32'(exp_fe));
        chk("cyc_pcm_l", 32'(pcm_l), 32'(cur_l));
        chk("cyc_pcm_r", 32'(pcm_r), 32'(cur_r));
`ifdef I2S_RX_MONO_MIX_EN
        chk("cyc_pcm_mono", 32'(pcm_mono), 32'(mono_of(cur_l, cur_r)));
`endif
        if (sample_valid === 1'b1) begin
            sv_seen++;
            last_sv_cyc = cyc;
        end
        if (frame_error === 1'b1) fe_seen++;
    end

    // One bclk period = 4 clk cycles; data set while bclk is low
    task automatic send_slot(input bit lr, input bit sd);
        @(negedge clk);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = sd;
        @(negedge clk);
        @(negedge clk);
        bclk = 1'b1;
        last_rise_cyc = cyc;
        model_rise(lr, sd, cyc + 3);
        @(negedge clk);
    endtask

    // lrclk moves to the next channel on the word's last slot (I2S one-bit delay)
    task automatic send_word(input bit ch, input logic [AB-1:0] w, input int n, input bit nxt);
        for (int k = 0; k < n; k++)
            send_slot((k == n - 1) ? nxt : ch, (k < int'(AB)) ? w[int'(AB) - 1 - k] : 1'b0);
    endtask

    task automatic send_frame(input logic [AB-1:0] l, input logic [AB-1:0] r, input int n,
                              input bit nxt);
        send_word(1'b0, l, n, 1'b1);
        send_word(1'b1, r, n, nxt);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bclk = 1'b0;
        idle(8);
        reset = 1'b1;
        model_reset(cyc + 1);
        idle(4);
        reset = 1'b0;
        idle(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int f0;
        reset = 1'b1;
        bclk  = 1'b0;
        lrclk = 1'b0;
        sdata = 1'b0;
        ev_rst[1] = 1'b1;
        idle(4);
        chk("rst_pcm_l", 32'(pcm_l), 32'h0);
        chk("rst_pcm_r", 32'(pcm_r), 32'h0);
        chk("rst_sample_valid", 32'(sample_valid), 32'h0);
        chk("rst_frame_error", 32'(frame_error), 32'h0);
        reset = 1'b0;
        idle(4);

        // Standard 32-slot frames; first frame only synchronizes
        s0 = sv_seen;
        f0 = fe_seen;
        repeat (4) send_frame(16'h8001, 16'h7FFE, 32, 1'b0);
        idle(6);
        chk("std_pulses", 32'(sv_seen - s0), 32'd3);
        chk("std_errors", 32'(fe_seen - f0), 32'd0);
        chk("std_pcm_l", 32'(pcm_l), 32'h8001);
        chk("std_pcm_r", 32'(pcm_r), 32'h7FFE);
        chk("latency", 32'(last_sv_cyc - last_rise_cyc), 32'd3);

        // Reset in the middle of a right word
        send_word(1'b0, 16'h1111, 32, 1'b1);
        send_word(1'b1, 16'h2222, 10, 1'b1);
        do_reset();
        s0 = sv_seen;
        send_word(1'b1, 16'h0000, 22, 1'b0);
        idle(6);
        chk("resync_no_pulse", 32'(sv_seen - s0), 32'd0);
        chk("resync_pcm_l_cleared", 32'(pcm_l), 32'h0);
        send_frame(16'h1234, 16'h5678, 32, 1'b0);
        idle(6);
        chk("resync_first_pair", 32'(sv_seen - s0), 32'd1);
        send_frame(16'h1234, 16'h5678, 32, 1'b0);
        idle(6);
        chk("resync_pulses", 32'(sv_seen - s0), 32'd2);
        chk("resync_pcm_l", 32'(pcm_l), 32'h1234);
        chk("resync_pcm_r", 32'(pcm_r), 32'h5678);

        // Short 12-slot words: zero padded, every commit flags an error
        s0 = sv_seen;
        f0 = fe_seen;
        repeat (3) send_frame(16'hABC0, 16'h1230, 12, 1'b0);
        idle(6);
        chk("short_pulses", 32'(sv_seen - s0), 32'd3);
        chk("short_errors", 32'(fe_seen - f0), 32'd6);
        chk("short_pcm_l", 32'(pcm_l), 32'hABC0);
        chk("short_pcm_r", 32'(pcm_r), 32'h1230);

        // lrclk stuck high for about three frame times
        s0 = sv_seen;
        send_frame(16'hAAAA, 16'h5555, 32, 1'b1);
        repeat (160) send_slot(1'b1, 1'($urandom_range(1, 0)));
        idle(6);
        chk("stuck_no_pulse", 32'(sv_seen - s0), 32'd0);
        send_slot(1'b0, 1'($urandom_range(1, 0)));
        send_frame(16'h0001, 16'h0002, 32, 1'b0);
        idle(6);
        chk("unstuck_pcm_l", 32'(pcm_l), 32'h0001);
        chk("unstuck_pcm_r", 32'(pcm_r), 32'h0002);

`ifdef I2S_RX_MONO_MIX_EN
        send_frame(16'h7FFF, 16'h0001, 32, 1'b0);
        idle(6);
        chk("mono_pos", 32'(pcm_mono), 32'h4000);
        send_frame(16'h8000, 16'hFFFF, 32, 1'b0);
        idle(6);
        chk("mono_neg", 32'(pcm_mono), 32'hBFFF);
`endif

        idle(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
